cp0_unit: RTL and testbench
===========================

CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk (in, 1) and reset (in, 1).
REQ-002 en (in, 1) SHALL be the mtc0 write enable from the M stage.
REQ-003 CP0Add (in, 5) SHALL be the CP0 register number for mfc0 and mtc0.
REQ-004 CP0In (in, 32) SHALL be the mtc0 write data.
REQ-005 CP0Out (out, 32) SHALL be the mfc0 read data.
REQ-006 VPC (in, 32) SHALL be the PC of the M-stage victim instruction.
REQ-007 BDIn (in, 1) SHALL flag that the victim instruction is in a branch delay slot.
REQ-008 ExcCodeIn (in, 5) SHALL be the victim exception code; 0 means none.
REQ-009 HWInt (in, 6) SHALL carry the level-sensitive hardware interrupt lines.
REQ-010 EXLClr (in, 1) SHALL flag that eret is in the M stage.
REQ-011 EPCOut (out, 32) SHALL be the current EPC value, used as the eret target.
REQ-012 Req (out, 1) SHALL be the exception/interrupt request; it flushes all pipeline registers and redirects fetch to 0x4180.

Function
REQ-013 The block SHALL hold SR (reg 12), Cause (reg 13) and EPC (reg 14); every other CP0Add SHALL read 0 and ignore writes.
REQ-014 SR fields: IM = SR[15:10], EXL = SR[1], IE = SR[0]; all other SR bits SHALL read 0.
REQ-015 Cause fields: BD = [31], IP = [15:10], ExcCode = [6:2]; all other Cause bits SHALL read 0.
REQ-016 IntReq SHALL equal |(HWInt & IM) & IE & ~EXL.
REQ-017 ExcReq SHALL equal (ExcCodeIn != 0) & ~EXL.
REQ-018 Req SHALL be combinational and equal IntReq | ExcReq.
REQ-019 Interrupts SHALL take priority over exceptions: when IntReq is high, Cause.ExcCode SHALL be written 0 (Int); otherwise it SHALL be written ExcCodeIn.
REQ-020 On a clock edge with Req high, the block SHALL set EXL = 1, write Cause.BD = BDIn, and write EPC = BDIn ? {VPC[31:2],2'b00} - 4 : {VPC[31:2],2'b00}.
REQ-021 Cause.IP SHALL be loaded from HWInt on every clock edge, independent of Req and en.
REQ-022 On an edge with EXLClr high and Req low, EXL SHALL be cleared to 0.
REQ-023 mtc0 (en high, Req low) SHALL write only SR.IM/EXL/IE or EPC; writes to Cause SHALL be ignored.
REQ-024 When Req and en are high in the same cycle, Req SHALL win and the mtc0 write SHALL be discarded.
REQ-025 When Req and EXLClr are high in the same cycle, Req SHALL win and EXL SHALL remain set.
REQ-026 Register writes SHALL become visible one cycle later; CP0Out SHALL be a combinational read of the current register state, with no write-through.
REQ-027 EPCOut SHALL be combinational from the EPC register.
REQ-028 While EXL = 1, Req SHALL be 0 regardless of HWInt or ExcCodeIn, so nested exceptions are blocked.

Reset
REQ-029 A synchronous reset SHALL clear SR, Cause and EPC to 0, so Req = 0, CP0Out = 0 and EPCOut = 0 after the edge.
REQ-030 Reset SHALL override Req, en and EXLClr in the same cycle.

Configuration
REQ-031 With CP0_HWINT_EN defined, interrupts SHALL behave as in REQ-016 and REQ-021.
REQ-032 With CP0_HWINT_EN undefined, IntReq SHALL be 0, Cause.IP SHALL read 0 and HWInt SHALL be ignored; SR.IM SHALL remain writable and readable.

Structure
REQ-033 A shared package SHALL hold: ExcCode constants (Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12), register numbers (SR=12, Cause=13, EPC=14), the handler address 32'h0000_4180, and the SR/Cause field bit positions.
REQ-034 A single combinational sub-module, cp0_req_gen, SHALL compute IntReq, ExcReq, Req and the selected ExcCode.

Verification
REQ-035 Reset, then mfc0 of regs 12, 13 and 14 -> each returns 0; Req = 0.
REQ-036 ExcCodeIn=10, VPC=0x3010, BDIn=0 -> Req=1 that cycle; next cycle EPC=0x3010, Cause.ExcCode=10, EXL=1.
REQ-037 ExcCodeIn=12, VPC=0x3024, BDIn=1 -> EPC=0x3020, Cause.BD=1.
REQ-038 mtc0 SR=0x0000_0401, then HWInt=6'b000001 -> Req=1, Cause.ExcCode=0; a simultaneous ExcCodeIn=4 SHALL NOT win.
REQ-039 With EXL=1, ExcCodeIn=8 -> Req=0; then EXLClr=1 -> EXL=0 next cycle, and ExcCodeIn=8 -> Req=1.
REQ-040 en=1, CP0Add=14, CP0In=0x5000 with ExcCodeIn=4, VPC=0x3000 -> EPC=0x3000 (the write is discarded); without CP0_HWINT_EN, HWInt=6'h3F with IE=1 and IM all ones -> Req=0.

Source files
------------

// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared CP0 constants (exception codes, register numbers, handler address, field positions)
package cp0_unit_pkg;
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI = 5'd10;
  localparam logic [4:0] EXC_OV = 5'd12;
  localparam logic [4:0] REG_SR = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC = 5'd14;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;
  localparam int SR_IM_HI = 15;
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL = 1;
  localparam int SR_IE = 0;
  localparam int CAUSE_BD = 31;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_EXC_LO = 2;
endpackage

// File: rtl/cp0_req_gen.sv
// cp0_req_gen: combinational interrupt/exception request and ExcCode selection
import cp0_unit_pkg::*;
module cp0_req_gen (
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_in,
  output logic       int_req,
  output logic       exc_req,
  output logic       req,
  output logic [4:0] exc_code
);
  assign int_req = |(hw_int & im) & ie & ~exl;
  assign exc_req = (exc_code_in != 5'd0) & ~exl;
  assign req = int_req | exc_req;
  assign exc_code = int_req ? EXC_INT : exc_code_in;
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: MIPS CP0 with SR/Cause/EPC and exception/interrupt request generation.
// Hardware interrupts are compiled in only when CP0_HWINT_EN is defined.
import cp0_unit_pkg::*;
module cp0_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] EPCOut,
  output logic        Req
);
  logic [5:0] im, ip, hw_eff;
  logic exl, ie, bd, int_req, exc_req;
  logic [4:0] exc_code, exc_sel;
  logic [31:0] epc, sr_val, cause_val, pc_al;
`ifdef CP0_HWINT_EN
  assign hw_eff = HWInt;
`else
  logic unused_hw;
  assign hw_eff = 6'd0;
  assign unused_hw = ^HWInt;
`endif
  cp0_req_gen u_req (
    .hw_int(hw_eff),
    .im(im),
    .ie(ie),
    .exl(exl),
    .exc_code_in(ExcCodeIn),
    .int_req(int_req),
    .exc_req(exc_req),
    .req(Req),
    .exc_code(exc_sel)
  );
  assign pc_al = VPC & ~32'd3;
  assign sr_val = {16'h0, im, 8'h0, exl, ie};
  assign cause_val = {bd, 15'h0, ip, 3'h0, exc_code, 2'h0};
  assign CP0Out = CP0Add == REG_SR ? sr_val : CP0Add == REG_CAUSE ? cause_val : CP0Add == REG_EPC ? epc : 32'h0;
  assign EPCOut = epc;
  always_ff @(posedge clk) begin
    if (reset) begin
      im <= '0;
      exl <= 1'b0;
      ie <= 1'b0;
      bd <= 1'b0;
      ip <= '0;
      exc_code <= '0;
      epc <= '0;
    end else begin
      ip <= hw_eff;
      if (Req) begin
        exl <= 1'b1;
        bd <= BDIn;
        exc_code <= exc_sel;
        epc <= BDIn ? pc_al - 32'd4 : pc_al;
      end else begin
        if (EXLClr) exl <= 1'b0;
        if (en && CP0Add == REG_SR) begin
          im <= CP0In[SR_IM_HI:SR_IM_LO];
          exl <= CP0In[SR_EXL];
          ie <= CP0In[SR_IE];
        end
        if (en && CP0Add == REG_EPC) epc <= CP0In;
      end
    end
  end
endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit
module tb_cp0_unit;
  logic clk = 0, reset = 1, en = 0, BDIn = 0, EXLClr = 0, Req;
  logic [4:0] CP0Add = 0, ExcCodeIn = 0;
  logic [31:0] CP0In = 0, VPC = 0, CP0Out, EPCOut;
  logic [5:0] HWInt = 0;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  cp0_unit dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add), .CP0In(CP0In), .CP0Out(CP0Out),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
    .EPCOut(EPCOut), .Req(Req)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    en = 0; CP0In = 0; VPC = 0; BDIn = 0; ExcCodeIn = 0; EXLClr = 0;
  endtask
  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    en = 0; CP0Add = a; #1;
    chk(tag, CP0Out, exp);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    en = 1; CP0Add = a; CP0In = d;
    tick;
    en = 0;
  endtask
  task automatic clr_exl;
    EXLClr = 1;
    tick;
    EXLClr = 0;
  endtask
  initial begin
    tick; reset = 0;
    chk("rst_req", {31'h0, Req}, 0);
    rd(12, "rst_sr", 0); rd(13, "rst_cause", 0); rd(14, "rst_epc", 0);
    chk("rst_epcout", EPCOut, 0);
    ExcCodeIn = 10; VPC = 32'h3010; #1;
    chk("ri_req", {31'h0, Req}, 1);
    tick; idle;
    chk("ri_epc", EPCOut, 32'h3010);
    rd(13, "ri_cause", 32'h28); rd(12, "ri_sr", 32'h2);
    ExcCodeIn = 8; #1;
    chk("nested_blocked", {31'h0, Req}, 0);
    ExcCodeIn = 0; clr_exl;
    rd(12, "eret_sr", 0);
    ExcCodeIn = 8; #1;
    chk("sys_req", {31'h0, Req}, 1);
    ExcCodeIn = 12; VPC = 32'h3024; BDIn = 1;
    tick; idle;
    chk("bd_epc", EPCOut, 32'h3020);
    rd(13, "bd_cause", 32'h8000_0030);
    clr_exl;
    ExcCodeIn = 5; VPC = 32'h3003; EXLClr = 1;
    tick; idle;
    rd(12, "req_vs_eret_sr", 32'h2); rd(13, "ades_cause", 32'h14);
    chk("align_epc", EPCOut, 32'h3000);
    clr_exl;
    wr(13, 32'hFFFF_FFFF); rd(13, "cause_ro", 32'h14);
    wr(3, 32'hFFFF_FFFF); rd(3, "unmapped", 0);
    wr(12, 32'h0000_0401); rd(12, "sr_wr", 32'h401);
    en = 1; CP0Add = 14; CP0In = 32'h5000; ExcCodeIn = 4; VPC = 32'h3000; #1;
    chk("discard_req", {31'h0, Req}, 1);
    tick; idle;
    chk("discard_epc", EPCOut, 32'h3000);
    rd(12, "discard_sr", 32'h403); rd(13, "adel_cause", 32'h10);
    clr_exl;
    rd(12, "clr_sr", 32'h401);
    en = 1; CP0Add = 14; CP0In = 32'h5000; #1;
    chk("no_wthru", CP0Out, 32'h3000);
    tick; en = 0;
    chk("epc_wr", EPCOut, 32'h5000);
    rd(14, "epc_rd", 32'h5000);
    HWInt = 6'b000001; ExcCodeIn = 4; VPC = 32'h3040; #1;
    chk("int_or_exc_req", {31'h0, Req}, 1);
    tick; idle;
`ifdef CP0_HWINT_EN
    rd(13, "int_prio_cause", 32'h400);
`else
    rd(13, "int_prio_cause", 32'h10);
`endif
    chk("int_epc", EPCOut, 32'h3040);
    rd(12, "int_sr", 32'h403);
    HWInt = 0; clr_exl;
    wr(12, 32'h0000_FC01); rd(12, "im_all", 32'hFC01);
    HWInt = 6'h3F; #1;
`ifdef CP0_HWINT_EN
    chk("hw_all_req", {31'h0, Req}, 1);
    tick;
    rd(13, "hw_all_cause", 32'hFC00);
`else
    chk("hw_all_req", {31'h0, Req}, 0);
    tick;
    rd(13, "hw_all_cause", 32'h10);
`endif
    HWInt = 0; ExcCodeIn = 10; en = 1; CP0Add = 12; CP0In = 1; EXLClr = 1; reset = 1;
    tick; reset = 0; idle;
    rd(12, "rst2_sr", 0); rd(13, "rst2_cause", 0);
    chk("rst2_epc", EPCOut, 0);
    chk("rst2_req", {31'h0, Req}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
